reg_scoreboard: RTL and testbench

- Hazard/issue controller for the decode stage and its 8-entry, 16-bit register file.
- Tracks destination registers of in-flight instructions that have not yet written back. Asserts stall when a decoded instruction reads a register with a pending write.
- Issues a retire strobe naming the register being written back each cycle.
- Sits between fetch/decode control and the register file write port; the first sequencing block for the pipelined processor.

---
 rtl/reg_scoreboard_pkg.sv | 30 +++
 rtl/reg_scoreboard_if.sv | 37 +++
 rtl/reg_scoreboard_sb_delay_line.sv | 47 ++++
 rtl/reg_scoreboard.sv | 114 +++++++++++
 tb/tb_reg_scoreboard.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_pkg
// Purpose  : Shared register-file geometry and delay-line entry type for the
//            decode-stage hazard scoreboard.
// Revision : 1.0  initial release
// ============================================================================
package scoreboard_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;

    // jal/jalr write the link register; decode resolves rd to this index
    localparam logic [REG_W-1:0] LINK_REG = 3'd7;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic             en,
        input logic [REG_W-1:0] r
    );
        reg_onehot    = '0;
        reg_onehot[r] = en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard_if
// Purpose  : Decode-side control bundle between the decode stage (master)
//            and the hazard scoreboard (slave).
// Revision : 1.0  initial release
// ============================================================================
interface reg_scoreboard_if;
    import scoreboard_pkg::*;

    logic             dec_valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
    logic             wr_en;
    logic [REG_W-1:0] rd;
    logic             flush;
    logic             stall;
    logic             issue;
    logic             busy;
    logic             retire_valid;
    logic [REG_W-1:0] retire_rd;
    logic             err;

    modport master (
        output dec_valid, rs, rt, use_rs, use_rt, wr_en, rd, flush,
        input  stall, issue, busy, retire_valid, retire_rd, err
    );

    modport slave (
        input  dec_valid, rs, rt, use_rs, use_rt, wr_en, rd, flush,
        output stall, issue, busy, retire_valid, retire_rd, err
    );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard_sb_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : sb_delay_line
// Purpose  : DEPTH-stage shift register of {v, rd} entries modelling the
//            EX..WB pipeline; cleared by reset or flush, exposes the tail.
// Revision : 1.0  initial release
// ============================================================================
module sb_delay_line
    import scoreboard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      i_flush,
    input  wire sb_entry_t i_entry,
    output sb_entry_t      o_tail,
    output logic           o_busy
);

    sb_entry_t        r_stage [DEPTH];
    logic [DEPTH-1:0] w_valid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_entry;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign w_valid[gi] = r_stage[gi].v;
        end
    endgenerate

    assign o_tail = r_stage[DEPTH-1];
    assign o_busy = |w_valid;

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Decode-stage RAW hazard scoreboard for the 8 x 16-bit register
//            file: per-register pending counters, stall/issue, retire strobe.
//            Optional macro RF_BYPASS_EN: write-before-read register file,
//            a source whose last pending write retires this cycle is clear.
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    reg_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    sb_entry_t                           w_in_entry;
    sb_entry_t                           w_tail;
    logic                                w_busy;
    logic                                w_hazard;
    logic                                w_stall;
    logic                                w_issue;
    logic                                w_wr_issue;
    logic                                w_err_set;
    logic [NUM_REGS-1:0]                 w_pend;
    logic [NUM_REGS-1:0]                 w_inc;
    logic [NUM_REGS-1:0]                 w_dec;
    logic [NUM_REGS-1:0][CNT_W-1:0]      r_cnt;
    logic                                r_err;

    assign w_dec = reg_onehot(w_tail.v, w_tail.rd);

    generate
        for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_pend
`ifdef RF_BYPASS_EN
            assign w_pend[gr] = (r_cnt[gr] - CNT_W'(w_dec[gr])) != '0;
`else
            assign w_pend[gr] = (r_cnt[gr] != '0);
`endif
        end
    endgenerate

    assign w_hazard   = sb.dec_valid &
                        ((sb.use_rs & w_pend[sb.rs]) | (sb.use_rt & w_pend[sb.rt]));
    assign w_stall    = w_hazard & ~sb.flush;
    assign w_issue    = sb.dec_valid & ~w_stall & ~sb.flush;
    assign w_wr_issue = w_issue & sb.wr_en;
    assign w_inc      = reg_onehot(w_wr_issue, sb.rd);

    // rd is zeroed for bubbles so retire_rd reads 0 whenever retire_valid is low
    assign w_in_entry.v  = w_wr_issue;
    assign w_in_entry.rd = w_wr_issue ? sb.rd : '0;

    sb_delay_line #(
        .DEPTH (DEPTH)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .i_flush (sb.flush),
        .i_entry (w_in_entry),
        .o_tail  (w_tail),
        .o_busy  (w_busy)
    );

    // Same-register inc+dec cancels; saturation and underflow hold the count
    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            r_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_inc[r] && !w_dec[r] && (r_cnt[r] != c_cnt_max)) begin
                    r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_err_set = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (w_inc[r] && !w_dec[r] && (r_cnt[r] == c_cnt_max)) begin
                w_err_set = 1'b1;
            end
            if (w_dec[r] && !w_inc[r] && (r_cnt[r] == '0)) begin
                w_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign sb.stall        = w_stall;
    assign sb.issue        = w_issue;
    assign sb.busy         = w_busy;
    assign sb.retire_valid = w_tail.v;
    assign sb.retire_rd    = w_tail.rd;
    assign sb.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Directed self-checking bench for reg_scoreboard with a retire
//            scoreboard queue; a second CNT_W=1 instance covers overflow.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;
    import scoreboard_pkg::*;

    localparam int D = 3;
`ifdef RF_BYPASS_EN
    localparam int RAW_REL = 3;
`else
    localparam int RAW_REL = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;

    typedef struct {
        logic [REG_W-1:0] rd;
        int               due;
    } exp_t;
    exp_t q[$];

    reg_scoreboard_if sif ();
    reg_scoreboard_if ovif ();

    reg_scoreboard #(.DEPTH(D), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sif)
    );

    reg_scoreboard #(.DEPTH(D), .CNT_W(1)) dut_ov (
        .clk (clk),
        .rst (rst),
        .sb  (ovif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic fl, input logic urs, input logic urt,
                         input logic we, input logic [2:0] rs_i, input logic [2:0] rt_i,
                         input logic [2:0] rd_i);
        sif.dec_valid = dv;
        sif.flush     = fl;
        sif.use_rs    = urs;
        sif.use_rt    = urt;
        sif.wr_en     = we;
        sif.rs        = rs_i;
        sif.rt        = rt_i;
        sif.rd        = rd_i;
    endtask

    task automatic drive_ov(input logic dv, input logic we, input logic [2:0] rd_i);
        ovif.dec_valid = dv;
        ovif.flush     = 1'b0;
        ovif.use_rs    = 1'b0;
        ovif.use_rt    = 1'b0;
        ovif.wr_en     = we;
        ovif.rs        = 3'd0;
        ovif.rt        = 3'd0;
        ovif.rd        = rd_i;
    endtask

    // Checks stall/issue and books the expected retire when a write issues
    task automatic expect_issue(input string tag, input logic st, input logic is);
        #2;
        chk({tag, "_stall"}, sif.stall, st);
        chk({tag, "_issue"}, sif.issue, is);
        if (is && sif.wr_en) q.push_back('{rd: sif.rd, due: cyc + D});
    endtask

    task automatic step_idle();
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_idle();
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("retire_valid", sif.retire_valid, 1);
                chk("retire_rd", sif.retire_rd, q[0].rd);
                void'(q.pop_front());
            end else begin
                chk("retire_idle", sif.retire_valid, 0);
            end
        end
    end

    initial begin
        // reset held two cycles with a writing instruction presented
        drive(1, 0, 0, 0, 1, 0, 0, 3);
        drive_ov(0, 0, 0);
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        #2;
        chk("rst_stall", sif.stall, 0);
        chk("rst_issue", sif.issue, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_retire_v", sif.retire_valid, 0);
        chk("rst_retire_rd", sif.retire_rd, 0);
        chk("rst_err", sif.err, 0);
        chk("rst_cnt", dut.r_cnt, 0);

        // RAW on rs: producer rd=2, consumer reads r2 and writes r5
        next(); drive(1, 0, 0, 0, 1, 0, 0, 2); expect_issue("raw_prod", 0, 1);
        for (int k = 1; k <= RAW_REL; k++) begin
            next();
            drive(1, 0, 1, 0, 1, 2, 0, 5);
            expect_issue($sformatf("raw_c%0d", k), k < RAW_REL, k == RAW_REL);
        end
        idle(D + 1);
        chk("raw_busy_drained", sif.busy, 0);
        chk("raw_cnt5", dut.r_cnt[5], 0);

        // independent sources, then rt hazard and use_rt gating
        next(); drive(1, 0, 0, 0, 1, 0, 0, 1); expect_issue("ind_prod", 0, 1);
        next(); drive(1, 0, 1, 1, 0, 4, 5, 0); expect_issue("ind_cons", 0, 1);
        next(); drive(1, 0, 0, 1, 0, 0, 1, 0); expect_issue("rt_haz", 1, 0);
        chk("rt_busy", sif.busy, 1);
        next(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_issue("rt_unused", 0, 1);
        idle(D + 1);

        // back-to-back writes to the link register
        next(); drive(1, 0, 0, 0, 1, 0, 0, LINK_REG); expect_issue("jal0", 0, 1);
        next(); drive(1, 0, 0, 0, 1, 0, 0, LINK_REG); expect_issue("jal1", 0, 1);
        step_idle(); chk("jal_cnt_c2", dut.r_cnt[7], 2);
        step_idle(); chk("jal_cnt_c3", dut.r_cnt[7], 2);
        step_idle(); chk("jal_cnt_c4", dut.r_cnt[7], 1);
        step_idle(); chk("jal_cnt_c5", dut.r_cnt[7], 0);
        chk("jal_err", sif.err, 0);
        idle(1);

        // flush: r1 retires during the flush cycle, r6 is killed in flight
        next(); drive(1, 0, 0, 0, 1, 0, 0, 1); expect_issue("fl_p1", 0, 1);
        step_idle();
        next(); drive(1, 0, 0, 0, 1, 0, 0, 6); expect_issue("fl_p6", 0, 1);
        next(); drive(1, 1, 1, 0, 1, 6, 0, 4); expect_issue("fl_cyc", 0, 0);
        @(negedge clk);
        #1;
        q.delete();
        step_idle();
        chk("fl_cnt6", dut.r_cnt[6], 0);
        chk("fl_cnt1", dut.r_cnt[1], 0);
        chk("fl_busy", sif.busy, 0);
        idle(D + 1);

        // saturation on the CNT_W=1 instance
        next(); drive_ov(1, 1, 0); #2; chk("ov_issue0", ovif.issue, 1);
        next(); drive_ov(1, 1, 0); #2; chk("ov_issue1", ovif.issue, 1);
        chk("ov_err_pre", ovif.err, 0);
        next(); drive_ov(0, 0, 0); #2;
        chk("ov_err", ovif.err, 1);
        chk("ov_cnt_sat", dut_ov.r_cnt[0], 1);
        idle(5);
        chk("ov_err_sticky", ovif.err, 1);

        // reset mid-flight: the pending r2 write must never retire
        next(); drive(1, 0, 0, 0, 1, 0, 0, 2);
        next(); drive(0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1; q.delete();
        next(); rst = 1'b0; #2;
        chk("mid_rst_busy", sif.busy, 0);
        chk("mid_rst_cnt", dut.r_cnt, 0);
        chk("mid_rst_err", sif.err, 0);
        chk("ov_err_cleared", ovif.err, 0);
        idle(D + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
